// File: rtl/ring_contactor_sequencer.sv
// Ring contactor sequencer: services one contactor transition at a time in round-robin
// order, vetoes forbidden closes, confirms on feedback and trips everything open on faults.
module ring_contactor_sequencer #(
   parameter int TIMEOUT_CYC = 1000,
   parameter int SETTLE_CYC  = 50,
   parameter int CNT_W       = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_req,
   input  logic [7:0] i_fb,
   input  logic       i_fault_clr,
   output logic [7:0] o_cmd,
   output logic       o_busy,
   output logic       o_reject,
   output logic [2:0] o_reject_id,
   output logic       o_fault,
   output logic [1:0] o_fault_code,
   output logic [2:0] o_fault_id
);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WAIT_FB, S_SETTLE, S_FAULT} state_t;

   localparam logic [47:0] FORBID_MASKS = {8'hB9, 8'hB6, 8'hB1, 8'h6E, 8'h6B, 8'h70};
   localparam logic [1:0]  CODE_TIMEOUT = 2'd1;
   localparam logic [1:0]  CODE_UNEXP   = 2'd2;
   localparam logic [1:0]  CODE_FORBID  = 2'd3;

   state_t           state_reg, state_next;
   logic [2:0]       ptr_reg, ptr_next;
   logic [7:0]       blocked_reg, blocked_next;
   logic [7:0]       cmd_reg, cmd_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       target_reg, target_next;
   logic             reject_reg, reject_next;
   logic [2:0]       reject_id_reg, reject_id_next;
   logic [1:0]       code_reg, code_next;
   logic [2:0]       fid_reg, fid_next;

   logic [7:0] pending, pend_rot, target_onehot, close_pattern, unexp;
   logic [5:0] fb_hit, close_hit;
   logic [2:0] pick_idx;
   logic       fb_forbidden, close_forbidden, monitor_trip;

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

   assign pending       = (i_req ^ cmd_reg) & ~blocked_reg;
   assign target_onehot = 8'b1 << target_reg;
   assign close_pattern = cmd_reg | target_onehot;

   // Rotate pending so bit 0 is the pointer position; lowest set bit is then the next in turn.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rot
         assign pend_rot[gi] = pending[ptr_reg + 3'(gi)];
      end
      for (gi = 0; gi < 6; gi++) begin : g_forbid
         localparam logic [7:0] M = FORBID_MASKS[gi*8 +: 8];
         assign fb_hit[gi]    = (i_fb & M) == M;
         assign close_hit[gi] = (close_pattern & M) == M;
      end
   endgenerate

   assign pick_idx        = ptr_reg + lowest_set(pend_rot);
   assign fb_forbidden    = |fb_hit;
   assign close_forbidden = |close_hit;
   // In IDLE every bit must agree; otherwise the contactor being moved is exempt.
   assign unexp           = (i_fb ^ cmd_reg) & ~((state_reg == S_IDLE) ? 8'h00 : target_onehot);
   assign monitor_trip    = (state_reg != S_FAULT) && (fb_forbidden || (|unexp));

   always_comb begin
      state_next     = state_reg;
      ptr_next       = ptr_reg;
      blocked_next   = blocked_reg & i_req;
      cmd_next       = cmd_reg;
      cnt_next       = cnt_reg;
      target_next    = target_reg;
      reject_next    = 1'b0;
      reject_id_next = 3'd0;
      code_next      = code_reg;
      fid_next       = fid_reg;

      case (state_reg)
         S_IDLE: begin
            if (|pending) begin
               target_next = pick_idx;
               state_next  = S_CHECK;
            end
         end
         S_CHECK: begin
            cnt_next = '0;
            if (!i_req[target_reg] || !close_forbidden) begin
               cmd_next[target_reg] = i_req[target_reg];
               state_next           = S_WAIT_FB;
            end else begin
               reject_next              = 1'b1;
               reject_id_next           = target_reg;
               blocked_next[target_reg] = 1'b1;
               ptr_next                 = target_reg + 3'd1;
               state_next               = S_IDLE;
            end
         end
         S_WAIT_FB: begin
            if (i_fb[target_reg] == cmd_reg[target_reg]) begin
               cnt_next   = '0;
               state_next = S_SETTLE;
            end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
               cmd_next   = 8'h00;
               code_next  = CODE_TIMEOUT;
               fid_next   = target_reg;
               state_next = S_FAULT;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt_reg == CNT_W'(SETTLE_CYC - 1)) begin
               cnt_next   = '0;
               ptr_next   = target_reg + 3'd1;
               state_next = S_IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_FAULT: begin
            cmd_next = 8'h00;
            if (i_fault_clr && (i_fb == 8'h00)) begin
               code_next    = 2'd0;
               fid_next     = 3'd0;
               blocked_next = 8'h00;
               state_next   = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // Feedback monitors outrank whatever the current state decided this cycle.
      if (monitor_trip) begin
         state_next     = S_FAULT;
         cmd_next       = 8'h00;
         cnt_next       = '0;
         ptr_next       = ptr_reg;
         reject_next    = 1'b0;
         reject_id_next = 3'd0;
         if (fb_forbidden) begin
            code_next = CODE_FORBID;
            fid_next  = 3'd5;
         end else begin
            code_next = CODE_UNEXP;
            fid_next  = lowest_set(unexp);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg     <= S_IDLE;
         ptr_reg       <= 3'd0;
         blocked_reg   <= 8'h00;
         cmd_reg       <= 8'h00;
         cnt_reg       <= '0;
         target_reg    <= 3'd0;
         reject_reg    <= 1'b0;
         reject_id_reg <= 3'd0;
         code_reg      <= 2'd0;
         fid_reg       <= 3'd0;
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         blocked_reg   <= blocked_next;
         cmd_reg       <= cmd_next;
         cnt_reg       <= cnt_next;
         target_reg    <= target_next;
         reject_reg    <= reject_next;
         reject_id_reg <= reject_id_next;
         code_reg      <= code_next;
         fid_reg       <= fid_next;
      end
   end

   assign o_cmd        = cmd_reg;
   assign o_busy       = (state_reg == S_CHECK) || (state_reg == S_WAIT_FB) || (state_reg == S_SETTLE);
   assign o_reject     = reject_reg;
   assign o_reject_id  = reject_id_reg;
   assign o_fault      = (state_reg == S_FAULT);
   assign o_fault_code = code_reg;
   assign o_fault_id   = fid_reg;

endmodule
